// File: rtl/grid_claim_arbiter_pkg.sv
// Shared definitions for the grid claim arbiter: op codes, FSM states and grid geometry.
package grid_claim_arbiter_pkg;

    localparam int GRID_N         = 12;
    localparam int GRID_CELLS_DEF = GRID_N * GRID_N;
    localparam logic [31:0] EMPTY_CELL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLAIM = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RD_WAIT,
        ST_CHECK,
        ST_WR,
        ST_RESP
    } state_e;

    // The reserved encoding behaves exactly like a read.
    function automatic op_e decode_op(input logic [1:0] raw);
        op_e op;
        case (raw)
            2'b01:   op = OP_WRITE;
            2'b10:   op = OP_CLAIM;
            default: op = OP_READ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/grid_claim_arbiter_rr_arbiter.sv
// Round-robin pick of the first requester at or after the pointer; pointer moves past the winner on en_i.
module grid_claim_arbiter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    output logic             vld_o,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    always_comb begin
        vld_o   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!vld_o && req_i[cand]) begin
                vld_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en_i && vld_o) begin
            ptr_q <= (idx_o == IDX_W'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/grid_claim_arbiter.sv
// Serialises engine accesses to the grid RAM, provides atomic read-if-empty-then-write claims,
// and sweeps the whole grid to EMPTY on request.
module grid_claim_arbiter
    import grid_claim_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int GRID_CELLS = GRID_CELLS_DEF,
    parameter logic [DATA_W-1:0] EMPTY = DATA_W'(EMPTY_CELL)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_start,
    output logic                      clear_busy,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [2*N_REQ-1:0]        req_op,
    input  logic [ADDR_W*N_REQ-1:0]   req_addr,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_ok,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(GRID_CELLS - 1);
    localparam logic [ADDR_W:0]   CELL_LIMIT = (ADDR_W + 1)'(GRID_CELLS);

    state_e              state_q;
    op_e                 lat_op_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_data_q;
    logic [N_REQ-1:0]    lat_owner_q;
    logic                res_ok_q;
    logic [DATA_W-1:0]   res_data_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clear_pending_q;

    logic                clear_busy_q;
    logic [N_REQ-1:0]    req_ready_q;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic                rsp_ok_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                mem_re_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;

    logic                grant_vld;
    logic                grant_take;
    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    op_e                 sel_op;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Handshake: an engine holds req_valid and its fields until req_ready pulses for it; the
    // single rsp_valid pulse for that engine later carries rsp_ok/rsp_data. Only one transaction
    // is in flight, so a claim's read and conditional write cannot interleave with another engine.
    assign grant_take = (state_q == ST_IDLE) && !clear_pending_q && !clear_start;

    grid_claim_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req_valid),
        .en_i    (grant_take),
        .vld_o   (grant_vld),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    always_comb begin
        sel_op   = decode_op(req_op[int'(grant_idx)*2 +: 2]);
        sel_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            lat_op_q        <= OP_READ;
            lat_addr_q      <= '0;
            lat_data_q      <= '0;
            lat_owner_q     <= '0;
            res_ok_q        <= 1'b0;
            res_data_q      <= '0;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            clear_busy_q    <= 1'b0;
            req_ready_q     <= '0;
            rsp_valid_q     <= '0;
            rsp_ok_q        <= 1'b0;
            rsp_data_q      <= '0;
            mem_re_q        <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_din_q       <= '0;
        end else begin
            req_ready_q <= '0;
            if (clear_start && state_q != ST_IDLE) begin
                clear_pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clear_pending_q || clear_start) begin
                        clear_pending_q <= 1'b0;
                        clear_busy_q    <= 1'b1;
                        clr_cnt_q       <= '0;
                        mem_we_q        <= 1'b1;
                        mem_addr_q      <= '0;
                        mem_din_q       <= EMPTY;
                        state_q         <= ST_CLEAR;
                    end else if (grant_vld) begin
                        req_ready_q <= grant;
                        lat_owner_q <= grant;
                        lat_op_q    <= sel_op;
                        lat_addr_q  <= sel_addr;
                        lat_data_q  <= sel_data;
                        if ({1'b0, sel_addr} >= CELL_LIMIT) begin
                            res_ok_q   <= 1'b0;
                            res_data_q <= EMPTY;
                            state_q    <= ST_RESP;
                        end else if (sel_op == OP_WRITE) begin
                            res_ok_q   <= 1'b1;
                            res_data_q <= sel_data;
                            state_q    <= ST_WR;
                        end else begin
                            state_q <= ST_RD_WAIT;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == LAST_CELL) begin
                        mem_we_q     <= 1'b0;
                        clear_busy_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        clr_cnt_q  <= clr_cnt_q + 1'b1;
                        mem_addr_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_WR: begin
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= lat_addr_q;
                    mem_din_q  <= lat_data_q;
                    state_q    <= ST_RESP;
                end
                // First cycle issues the read, second cycle waits for the RAM output register.
                ST_RD_WAIT: begin
                    if (!mem_re_q) begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= lat_addr_q;
                    end else begin
                        mem_re_q <= 1'b0;
                        state_q  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rsp_valid_q <= lat_owner_q;
                    state_q     <= ST_RESP;
                    if (lat_op_q == OP_CLAIM && mem_dout == EMPTY) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= lat_addr_q;
                        mem_din_q  <= lat_data_q;
                        rsp_ok_q   <= 1'b1;
                        rsp_data_q <= lat_data_q;
                    end else begin
                        rsp_ok_q   <= (lat_op_q != OP_CLAIM);
                        rsp_data_q <= mem_dout;
                    end
                end
                ST_RESP: begin
                    mem_we_q <= 1'b0;
                    if (rsp_valid_q == '0) begin
                        rsp_valid_q <= lat_owner_q;
                        rsp_ok_q    <= res_ok_q;
                        rsp_data_q  <= res_data_q;
                    end else begin
                        rsp_valid_q <= '0;
                        rsp_ok_q    <= 1'b0;
                        rsp_data_q  <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign clear_busy = clear_busy_q;
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ok     = rsp_ok_q;
    assign rsp_data   = rsp_data_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule
